// File: rtl/sides_feeder.sv
// rtl/sides_feeder.sv - side-pair FIFO feeding the perimeter unit over a _dav/rfd handshake
module sides_feeder #(
    parameter int W     = 4,
    parameter int DEPTH = 4,
    parameter int CW    = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wr,
    input  logic [W-1:0]             a_in,
    input  logic [W-1:0]             b_in,
    output logic                     full,
    output logic                     empty,
    output logic                     ovf,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     _dav,
    input  logic                     rfd,
    output logic [W-1:0]             a,
    output logic [W-1:0]             b,
    output logic [CW-1:0]            sent
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   LVL_ONE  = 1;
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [CW-1:0] SENT_ONE = 1;

    typedef enum logic [1:0] {IDLE, SETUP, VALID, RELEASE} state_t;

    state_t            state;
    state_t            state_nx;
    logic [2*W-1:0]    mem [DEPTH];
    logic [AW-1:0]     head;
    logic [AW-1:0]     tail;
    logic [AW:0]       level_nx;
    logic              load;
    logic              pop;
    logic              done;
    logic              push;

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        pop      = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && rfd) begin
                    load     = 1'b1;
                    state_nx = SETUP;
                end
            end
            SETUP: state_nx = VALID;
            VALID: begin
                if (!rfd) begin
                    pop      = 1'b1;
                    state_nx = RELEASE;
                end
            end
            RELEASE: begin
                if (rfd) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // A pop in the same cycle frees a slot, so a write while full is still accepted.
    always_comb begin
        push     = wr && (!full || pop);
        level_nx = level;
        case ({push, pop})
            2'b10:   level_nx = level + LVL_ONE;
            2'b01:   level_nx = level - LVL_ONE;
            default: level_nx = level;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[tail] <= {a_in, b_in};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            head  <= '0;
            tail  <= '0;
            level <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
            ovf   <= 1'b0;
            a     <= '0;
            b     <= '0;
            sent  <= '0;
            _dav  <= 1'b1;
        end else begin
            state <= state_nx;
            if (push) begin
                tail <= tail + PTR_ONE;
            end
            if (pop) begin
                head <= head + PTR_ONE;
            end
            level <= level_nx;
            full  <= (level_nx == LVL_FULL);
            empty <= (level_nx == '0);
            if (wr && !push) begin
                ovf <= 1'b1;
            end
            if (load) begin
                {a, b} <= mem[head];
            end
            if (done) begin
                sent <= sent + SENT_ONE;
            end
            _dav <= (state_nx != VALID);
        end
    end

endmodule
